mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 No parameters; data width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_result  input  32  EX ALU result; effective address for loads/stores.
REQ-005 i_data_store  input  32  EX store data (rs2), zero for non-stores.
REQ-006 i_pc  input  32  PC of the instruction.
REQ-007 i_func3  input  3  access size/sign select.
REQ-008 i_opcode  input  7  opcode; load = 7'b0000011, store = 7'b0100011.
REQ-009 i_valid  input  1  EX presents a valid instruction.
REQ-010 o_stall  output  1  upstream SHALL hold all i_* stable while high.
REQ-011 o_dmem_req  output  1  data-memory request.
REQ-012 o_dmem_we  output  1  1 = write, 0 = read.
REQ-013 o_dmem_addr  output  32  word-aligned address.
REQ-014 o_dmem_wdata  output  32  lane-positioned store data.
REQ-015 o_dmem_be  output  4  byte enables (bit n = byte lane n).
REQ-016 i_dmem_rdata  input  32  read data, valid when i_dmem_ack high.
REQ-017 i_dmem_ack  input  1  single-cycle completion pulse.
REQ-018 o_wb_valid, o_wb_pc[31:0], o_wb_opcode[6:0], o_wb_data[31:0]  output  registered writeback bundle.
REQ-019 o_misaligned  output  1  registered misalignment flag (see Configuration).

Function
REQ-020 FSM states IDLE and WAIT; IDLE on reset.
REQ-021 IDLE, i_valid, non-memory opcode: next cycle o_wb_valid=1, o_wb_data=i_result, o_wb_pc/o_wb_opcode copied; o_stall=0 (latency 1).
REQ-022 IDLE, i_valid, load/store: o_dmem_req=1 combinationally, o_stall=1, go WAIT.
REQ-023 WAIT: o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be held constant; o_stall=1 while i_dmem_ack=0.
REQ-024 WAIT with i_dmem_ack=1: o_stall=0 that cycle, o_dmem_req stays 1 that cycle, go IDLE; writeback bundle valid next cycle.
REQ-025 i_dmem_ack while IDLE SHALL be ignored.
REQ-026 o_dmem_addr = {i_result[31:2],2'b00}; offset = i_result[1:0].
REQ-027 Stores: SB(000) be=4'b0001<<offset, wdata = byte replicated x4; SH(001) be=4'b0011<<offset, wdata = half replicated x2; SW(010) and any other func3 be=4'b1111.
REQ-028 Loads: select byte/half at offset from i_dmem_rdata; LB(000)/LH(001) sign-extend, LBU(100)/LHU(101) zero-extend, LW(010) and undefined func3 take full word.
REQ-029 Store retires with o_wb_valid=1, o_wb_data=0.
REQ-030 i_valid=0 in IDLE: o_wb_valid=0 next cycle, no request.
REQ-031 o_dmem_be=0, o_dmem_we=0, o_dmem_wdata=0 whenever o_dmem_req=0.

Reset
REQ-032 rst_n low: FSM->IDLE; o_dmem_req, o_stall, o_wb_valid, o_misaligned, all registered data outputs ->0 immediately.
REQ-033 Reset during WAIT abandons the access; a late ack after release is ignored per REQ-025.

Configuration
REQ-034 Macro MEM_MISALIGN_TRAP_EN defined: half access with offset[0]=1 or word access with offset!=0 issues no request, no stall; next cycle o_misaligned=1, o_wb_valid=0, o_wb_pc=i_pc.
REQ-035 Macro undefined: o_misaligned tied 0; misaligned accesses use offset with size-aligned low bits cleared (half: offset[0]=0; word: offset=0).

Verification
REQ-036 ADD result 0x1234 valid, no mem -> next cycle o_wb_valid=1, o_wb_data=0x00001234, o_dmem_req never high.
REQ-037 SB addr 0x103 data 0xAB, ack after 3 cycles -> addr 0x100, be=4'b1000, wdata=0xABABABAB, o_stall high 3 cycles, low in ack cycle.
REQ-038 LB addr 0x102, rdata 0x00800000 -> o_wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LH addr 0x201 with MEM_MISALIGN_TRAP_EN -> no req, o_misaligned=1 one cycle; without macro -> addr 0x200, lower half read.
REQ-040 rst_n low during WAIT, then ack pulse after release -> req drops at reset, o_wb_valid stays 0, FSM stays IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline memory stage between EX and WB.
//
// Non-memory instructions pass straight through to a registered writeback
// bundle (latency 1). Loads and stores raise a data-memory request and stall
// EX until the memory returns a single-cycle ack. Load data is lane-selected
// and sign/zero-extended. Store data is replicated across the byte lanes.
//
// Handshake: while o_stall is high, EX holds every i_* input stable. The
// request fields are therefore decoded directly from the held inputs and stay
// constant for the whole access. i_dmem_ack is a completion pulse. It is only
// honoured in WAIT. In the ack cycle o_stall is low, so EX may advance on that
// clock edge.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_result            EX result / effective address
//   i_data_store        store data (rs2)
//   i_pc, i_func3,
//   i_opcode, i_valid   instruction from EX
//   o_stall             hold EX
//   o_dmem_req/we/addr/wdata/be, i_dmem_rdata, i_dmem_ack   data-memory port
//   o_wb_valid/pc/opcode/data   registered writeback bundle
//   o_misaligned        registered misaligned-access trap flag
//   o_fsm_state         debug view of the FSM (0 = IDLE, 1 = WAIT)
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   When it is defined, misaligned half/word accesses are not issued and raise
//   o_misaligned. Otherwise the low address bits are forced to size alignment.
// -----------------------------------------------------------------------------
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_result,
   input  logic [31:0] i_data_store,
   input  logic [31:0] i_pc,
   input  logic [2:0]  i_func3,
   input  logic [6:0]  i_opcode,
   input  logic        i_valid,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_be,
   input  logic [31:0] i_dmem_rdata,
   input  logic        i_dmem_ack,
   output logic        o_wb_valid,
   output logic [31:0] o_wb_pc,
   output logic [6:0]  o_wb_opcode,
   output logic [31:0] o_wb_data,
   output logic        o_misaligned,
   output logic        o_fsm_state
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

   state_t      r_state, w_state_nxt;
   size_t       w_size;
   logic        w_is_load, w_is_store, w_is_mem;
   logic        w_req, w_stall, w_retire, w_trap, w_trap_cond;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_lane, w_load_data, w_wb_data;

   logic        r_wb_valid;
   logic [31:0] r_wb_pc, r_wb_data;
   logic [6:0]  r_wb_opcode;

   assign w_is_load  = (i_opcode == OP_LOAD);
   assign w_is_store = (i_opcode == OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;

   // Stores only know SB/SH; every other store func3 is a full word.
   // Loads treat the unsigned variants (func3[2]) as the same size.
   always_comb begin
      w_size = SZ_WORD;
      if (w_is_store) begin
         if (i_func3 == 3'b000)      w_size = SZ_BYTE;
         else if (i_func3 == 3'b001) w_size = SZ_HALF;
      end else begin
         if (i_func3 == 3'b000 || i_func3 == 3'b100)      w_size = SZ_BYTE;
         else if (i_func3 == 3'b001 || i_func3 == 3'b101) w_size = SZ_HALF;
      end
   end

   // Offset with the size-aligned low bits cleared.
   always_comb begin
      case (w_size)
         SZ_BYTE: w_off = i_result[1:0];
         SZ_HALF: w_off = {i_result[1], 1'b0};
         default: w_off = 2'b00;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap_cond = ((w_size == SZ_HALF) && i_result[0]) ||
                        ((w_size == SZ_WORD) && (i_result[1:0] != 2'b00));
`else
   assign w_trap_cond = 1'b0;
`endif

   always_comb begin
      case (w_size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{i_data_store[7:0]}};
         end
         SZ_HALF: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{i_data_store[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_data_store;
         end
      endcase
   end

   // Selected lane is shifted down to bit 0 before extension.
   assign w_lane = i_dmem_rdata >> {w_off, 3'b000};

   always_comb begin
      case (i_func3)
         3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b100:  w_load_data = {24'd0, w_lane[7:0]};
         3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b101:  w_load_data = {16'd0, w_lane[15:0]};
         default: w_load_data = w_lane;
      endcase
   end

   // rst_n gates the combinational request so it drops immediately in reset,
   // even while EX still presents a memory instruction.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_stall     = 1'b0;
      w_retire    = 1'b0;
      w_trap      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_valid && rst_n) begin
               if (!w_is_mem) begin
                  w_retire = 1'b1;
               end else if (w_trap_cond) begin
                  w_trap = 1'b1;
               end else begin
                  w_req       = 1'b1;
                  w_stall     = 1'b1;
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            w_req = 1'b1;
            if (i_dmem_ack) begin
               w_retire    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      if (w_trap || w_is_store) w_wb_data = 32'd0;
      else if (w_is_load)       w_wb_data = w_load_data;
      else                      w_wb_data = i_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid  <= 1'b0;
         r_wb_pc     <= 32'd0;
         r_wb_opcode <= 7'd0;
         r_wb_data   <= 32'd0;
      end else begin
         r_wb_valid <= w_retire;
         if (w_retire || w_trap) begin
            r_wb_pc     <= i_pc;
            r_wb_opcode <= i_opcode;
            r_wb_data   <= w_wb_data;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_misaligned;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_misaligned <= 1'b0;
      else        r_misaligned <= w_trap;
   end
   assign o_misaligned = r_misaligned;
`else
   assign o_misaligned = 1'b0;
`endif

   assign o_stall      = w_stall;
   assign o_dmem_req   = w_req;
   assign o_dmem_we    = w_req & w_is_store;
   assign o_dmem_addr  = {i_result[31:2], 2'b00};
   assign o_dmem_be    = w_req ? w_be : 4'b0000;
   assign o_dmem_wdata = (w_req && w_is_store) ? w_wdata : 32'd0;
   assign o_wb_valid   = r_wb_valid;
   assign o_wb_pc      = r_wb_pc;
   assign o_wb_opcode  = r_wb_opcode;
   assign o_wb_data    = r_wb_data;
   assign o_fsm_state  = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_result, i_data_store, i_pc, i_dmem_rdata;
   logic [2:0]  i_func3;
   logic [6:0]  i_opcode;
   logic        i_valid, i_dmem_ack;
   logic        o_stall, o_dmem_req, o_dmem_we, o_wb_valid, o_misaligned, o_fsm_state;
   logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_pc, o_wb_data;
   logic [3:0]  o_dmem_be;
   logic [6:0]  o_wb_opcode;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .i_result(i_result), .i_data_store(i_data_store), .i_pc(i_pc),
      .i_func3(i_func3), .i_opcode(i_opcode), .i_valid(i_valid),
      .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
      .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack),
      .o_wb_valid(o_wb_valid), .o_wb_pc(o_wb_pc), .o_wb_opcode(o_wb_opcode),
      .o_wb_data(o_wb_data), .o_misaligned(o_misaligned), .o_fsm_state(o_fsm_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int acc_size(input logic [6:0] op, input logic [2:0] f3);
      if (op == OP_STORE) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic int eff_off(input logic [31:0] addr, input int size);
      int off;
      off = int'(addr % 4);
      return (off / size) * size;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] rdata,
                                            input int off, input int size);
      logic [31:0] v;
      v = rdata >> (8 * off);
      if (size == 1) begin
         v = v & 32'hFF;
         if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2) begin
         v = v & 32'hFFFF;
         if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [31:0] st, input int size);
      if (size == 1) return (st & 32'hFF) * 32'h01010101;
      if (size == 2) return (st & 32'hFFFF) * 32'h00010001;
      return st;
   endfunction

   function automatic logic [3:0] store_be(input int off, input int size);
      int b;
      b = ((1 << size) - 1) << off;
      return b[3:0];
   endfunction

   logic        m_inflight = 1'b0, m_wb_valid = 1'b0, m_mis = 1'b0;
   logic [31:0] m_wb_pc = 32'd0, m_wb_data = 32'd0;
   logic [6:0]  m_wb_op = 7'd0;

   always @(negedge clk) begin : compare
      logic mem, is_st, mis, trap, e_req, e_stall;
      int sz, off;
      if (!rst_n) begin
         m_inflight = 1'b0; m_wb_valid = 1'b0; m_mis = 1'b0;
         m_wb_pc = 32'd0; m_wb_data = 32'd0; m_wb_op = 7'd0;
      end
      check("wb_valid", o_wb_valid, m_wb_valid);
      check("wb_pc", o_wb_pc, m_wb_pc);
      check("wb_opcode", o_wb_opcode, m_wb_op);
      check("wb_data", o_wb_data, m_wb_data);
      check("misaligned", o_misaligned, m_mis);
      check("fsm_state", o_fsm_state, m_inflight);

      is_st = (i_opcode == OP_STORE);
      mem   = (i_opcode == OP_LOAD) || is_st;
      sz    = acc_size(i_opcode, i_func3);
      off   = eff_off(i_result, sz);
      mis   = (i_result % 4) % sz != 0;
      trap  = TRAP_EN && rst_n && !m_inflight && i_valid && mem && mis;
      e_req   = rst_n && (m_inflight || (i_valid && mem && !trap));
      e_stall = e_req && !(m_inflight && i_dmem_ack);

      check("stall", o_stall, e_stall);
      check("dmem_req", o_dmem_req, e_req);
      check("dmem_we", o_dmem_we, e_req && is_st);
      if (e_req) begin
         check("dmem_addr", o_dmem_addr, i_result & ~32'd3);
         if (is_st) begin
            check("dmem_be", o_dmem_be, store_be(off, sz));
            check("dmem_wdata", o_dmem_wdata, store_wdata(i_data_store, sz));
         end else begin
            check("dmem_wdata_ld", o_dmem_wdata, 32'd0);
         end
      end else begin
         check("dmem_be_idle", o_dmem_be, 32'd0);
         check("dmem_wdata_idle", o_dmem_wdata, 32'd0);
      end

      if (rst_n) begin
         if (m_inflight && i_dmem_ack) begin
            m_wb_valid = 1'b1; m_wb_pc = i_pc; m_wb_op = i_opcode;
            m_wb_data  = is_st ? 32'd0 : load_val(i_func3, i_dmem_rdata, off, sz);
         end else if (!m_inflight && i_valid && !mem) begin
            m_wb_valid = 1'b1; m_wb_pc = i_pc; m_wb_op = i_opcode; m_wb_data = i_result;
         end else if (trap) begin
            m_wb_valid = 1'b0; m_wb_pc = i_pc; m_wb_op = i_opcode; m_wb_data = 32'd0;
         end else begin
            m_wb_valid = 1'b0;
         end
         m_mis      = trap;
         m_inflight = e_stall;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_valid = 1'b0; i_opcode = 7'd0; i_func3 = 3'd0;
      i_result = 32'd0; i_data_store = 32'd0; i_pc = 32'd0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] st);
      i_valid = 1'b1; i_pc = pc; i_opcode = op; i_func3 = f3;
      i_result = res; i_data_store = st;
   endtask

   task automatic do_mem(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] st,
                         input int lat, input logic [31:0] rdata);
      drive(pc, op, f3, res, st);
      repeat (lat) step();
      i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
      step();
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
      idle();
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : stim
      int stall_cnt;
      rst_n = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
      idle();
      step(); step();
      rst_n = 1'b1;
      step();

      // ALU passthrough
      drive(32'h1000, OP_ALU, 3'd0, 32'h1234, 32'd0);
      @(negedge clk);
      check("lit_add_noreq", o_dmem_req, 32'd0);
      step(); idle();
      @(negedge clk);
      check("lit_add_valid", o_wb_valid, 32'd1);
      check("lit_add_data", o_wb_data, 32'h00001234);
      check("lit_add_pc", o_wb_pc, 32'h1000);

      // SB 0x103, ack after three stall cycles
      step();
      drive(32'h2000, OP_STORE, 3'd0, 32'h103, 32'hAB);
      stall_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (o_stall) stall_cnt++;
         if (c == 0) begin
            check("lit_sb_addr", o_dmem_addr, 32'h100);
            check("lit_sb_be", o_dmem_be, 32'h8);
            check("lit_sb_wdata", o_dmem_wdata, 32'hABABABAB);
         end
         step();
      end
      i_dmem_ack = 1'b1;
      @(negedge clk);
      check("lit_sb_stall_cnt", stall_cnt, 32'd3);
      check("lit_sb_ack_stall", o_stall, 32'd0);
      check("lit_sb_ack_req", o_dmem_req, 32'd1);
      step(); i_dmem_ack = 1'b0; idle();
      @(negedge clk);
      check("lit_sb_wb_valid", o_wb_valid, 32'd1);
      check("lit_sb_wb_data", o_wb_data, 32'd0);

      // byte loads with sign / zero extension
      step();
      do_mem(32'h3000, OP_LOAD, 3'd0, 32'h102, 32'd0, 1, 32'h00800000);
      @(negedge clk);
      check("lit_lb", o_wb_data, 32'hFFFFFF80);
      do_mem(32'h3004, OP_LOAD, 3'd4, 32'h102, 32'd0, 2, 32'h00800000);
      @(negedge clk);
      check("lit_lbu", o_wb_data, 32'h00000080);

      // half loads, stores of each size, undefined func3 variants
      do_mem(32'h3008, OP_LOAD, 3'd1, 32'h206, 32'd0, 1, 32'h80010000);
      @(negedge clk);
      check("lit_lh", o_wb_data, 32'hFFFF8001);
      do_mem(32'h300C, OP_LOAD, 3'd5, 32'h206, 32'd0, 1, 32'h80010000);
      @(negedge clk);
      check("lit_lhu", o_wb_data, 32'h00008001);
      do_mem(32'h3010, OP_STORE, 3'd1, 32'h102, 32'h1234BEEF, 2, 32'd0);
      do_mem(32'h3014, OP_STORE, 3'd2, 32'h204, 32'hDEADBEEF, 1, 32'd0);
      do_mem(32'h3018, OP_STORE, 3'd7, 32'h208, 32'h01020304, 1, 32'd0);
      do_mem(32'h301C, OP_LOAD, 3'd2, 32'h300, 32'd0, 4, 32'hCAFEF00D);
      do_mem(32'h3020, OP_LOAD, 3'd3, 32'h304, 32'd0, 1, 32'h13572468);
      @(negedge clk);
      check("lit_ld_f3_3", o_wb_data, 32'h13572468);

      // ack while idle is ignored
      step();
      i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFFFFFF;
      step();
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
      @(negedge clk);
      check("lit_idle_ack", o_wb_valid, 32'd0);

      // misaligned half load at 0x201
      step();
`ifdef MEM_MISALIGN_TRAP_EN
      drive(32'h4000, OP_LOAD, 3'd1, 32'h201, 32'd0);
      @(negedge clk);
      check("lit_mis_noreq", o_dmem_req, 32'd0);
      check("lit_mis_nostall", o_stall, 32'd0);
      step(); idle();
      @(negedge clk);
      check("lit_mis_flag", o_misaligned, 32'd1);
      check("lit_mis_wbv", o_wb_valid, 32'd0);
      check("lit_mis_pc", o_wb_pc, 32'h4000);
      step();
      @(negedge clk);
      check("lit_mis_clear", o_misaligned, 32'd0);
      // misaligned word store also traps
      step();
      drive(32'h4004, OP_STORE, 3'd2, 32'h103, 32'h55AA55AA);
      step(); idle();
`else
      drive(32'h4000, OP_LOAD, 3'd1, 32'h201, 32'd0);
      @(negedge clk);
      check("lit_mis_addr", o_dmem_addr, 32'h200);
      step();
      i_dmem_ack = 1'b1; i_dmem_rdata = 32'h77778123;
      step();
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0; idle();
      @(negedge clk);
      check("lit_mis_lower", o_wb_data, 32'hFFFF8123);
      check("lit_mis_flag0", o_misaligned, 32'd0);
      do_mem(32'h4004, OP_STORE, 3'd2, 32'h103, 32'h55AA55AA, 1, 32'd0);
`endif

      // back-to-back ALU ops
      step();
      drive(32'h5000, OP_ALU, 3'd0, 32'hA5A5A5A5, 32'd0);
      step();
      drive(32'h5004, 7'b0010011, 3'd0, 32'h0000FFFF, 32'd0);
      step(); idle();
      @(negedge clk);
      check("lit_b2b_data", o_wb_data, 32'h0000FFFF);

      // reset during WAIT, then a late ack
      step();
      drive(32'h6000, OP_LOAD, 3'd2, 32'h400, 32'd0);
      step();
      @(negedge clk);
      check("lit_rst_wait", o_fsm_state, 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      check("lit_rst_req", o_dmem_req, 32'd0);
      check("lit_rst_stall", o_stall, 32'd0);
      step();
      idle();
      rst_n = 1'b1;
      step();
      i_dmem_ack = 1'b1; i_dmem_rdata = 32'h12345678;
      step();
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
      @(negedge clk);
      check("lit_late_ack_wbv", o_wb_valid, 32'd0);
      check("lit_late_ack_state", o_fsm_state, 32'd0);
      check("lit_late_ack_req", o_dmem_req, 32'd0);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
